dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge.sv | 153 +++++++++++++++
 tb/tb_dmem_bridge.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: connects the MEM stage of the pipeline to a simple request/ack data bus.
// Aligned loads and stores are registered onto the bus, and the pipeline is stalled
// until the bus acknowledges or the timeout expires. Misaligned accesses are rejected
// without starting a bus transaction.
module dmem_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreqM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic [1:0]  whbM,
  input  logic        lunsignedM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM,
  output logic        busfault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Normalised access size; whbM=11 decodes as a word.
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  // Final WAIT cycle index before the timeout fires (unused when TIMEOUT is 0).
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  lane;
  logic [1:0]  size;
  logic        lunsigned_q;
  logic [31:0] count;

  logic [1:0]  size_next;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_fmt;
  logic        accept;
  logic        expired;

  // Decode the MEM-stage request: size, alignment, lane enables and replicated store data.
  always_comb begin
    size_next  = SZ_WORD;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = writedataM;
    if (whbM == 2'b10) begin
      size_next  = SZ_BYTE;
      be_next    = 4'b0001 << aluoutM[1:0];
      wdata_next = {4{writedataM[7:0]}};
    end else if (whbM == 2'b01) begin
      size_next  = SZ_HALF;
      misaligned = aluoutM[0];
      be_next    = aluoutM[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{writedataM[15:0]}};
    end else begin
      misaligned = (aluoutM[1:0] != 2'b00);
    end
  end

  // Extract the addressed lane from the returned word and extend it to 32 bits.
  always_comb begin
    load_fmt = bus_rdata;
    case (size)
      SZ_BYTE: load_fmt = {{24{~lunsigned_q & bus_rdata[8*lane+7]}}, bus_rdata[8*lane +: 8]};
      SZ_HALF: begin
        if (lane[1])
          load_fmt = {{16{~lunsigned_q & bus_rdata[31]}}, bus_rdata[31:16]};
        else
          load_fmt = {{16{~lunsigned_q & bus_rdata[15]}}, bus_rdata[15:0]};
      end
      default: load_fmt = bus_rdata;
    endcase
  end

  assign accept  = (state == IDLE) && memreqM && !misaligned;
  assign expired = (TIMEOUT != 0) && (count == TO_LAST);
  assign stallM  = accept || (state == WAIT);

  // Transaction FSM: launches the bus access, waits for ack or timeout, then releases the stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lane        <= 2'b00;
      size        <= SZ_WORD;
      lunsigned_q <= 1'b0;
      count       <= 32'd0;
      readdataM   <= 32'd0;
      misalignM   <= 1'b0;
      busfault    <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_be      <= 4'b0000;
      bus_wdata   <= 32'd0;
    end else begin
      misalignM <= 1'b0;
      busfault  <= 1'b0;
      case (state)
        IDLE: begin
          if (memreqM) begin
            if (misaligned) begin
              misalignM <= 1'b1;
              readdataM <= 32'd0;
            end else begin
              lane        <= aluoutM[1:0];
              size        <= size_next;
              lunsigned_q <= lunsignedM;
              bus_we      <= memwriteM;
              bus_addr    <= {aluoutM[31:2], 2'b00};
              bus_be      <= be_next;
              bus_wdata   <= wdata_next;
              bus_req     <= 1'b1;
              count       <= 32'd0;
              state       <= WAIT;
            end
          end
        end
        WAIT: begin
          // An ack in the expiry cycle takes priority over the timeout.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we)
              readdataM <= load_fmt;
            state <= DONE;
          end else if (expired) begin
            bus_req   <= 1'b0;
            busfault  <= 1'b1;
            readdataM <= 32'd0;
            state     <= DONE;
          end else begin
            count <= count + 32'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed and randomized transactions against a behavioural model of
// the bridge's access rules (lane enables, replication, extension, timeout).
module tb_dmem_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreqM, memwriteM, lunsignedM;
  logic [31:0] aluoutM, writedataM;
  logic [1:0]  whbM;
  logic [31:0] readdataM;
  logic        stallM, misalignM, busfault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ack;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_rd = 32'd0;

  dmem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .memreqM(memreqM), .memwriteM(memwriteM),
    .aluoutM(aluoutM), .writedataM(writedataM), .whbM(whbM), .lunsignedM(lunsignedM),
    .readdataM(readdataM), .stallM(stallM), .misalignM(misalignM), .busfault(busfault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from the whb code (11 behaves as a word).
  function automatic int nbytes(input logic [1:0] whb);
    if (whb == 2'b10) return 1;
    if (whb == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [1:0] whb, input logic [31:0] a);
    return (a % nbytes(whb)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] whb, input logic [31:0] a);
    int n = nbytes(whb);
    int off = (n == 4) ? 0 : int'(a % 4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] whb, input logic [31:0] d);
    int n = nbytes(whb);
    if (n == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] whb, input logic [31:0] a,
                                           input logic [31:0] rd, input logic uns);
    int n = nbytes(whb);
    int off = (n == 4) ? 0 : int'(a % 4);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    logic [31:0] v = (rd >> (8 * off)) & mask;
    if (!uns && n < 4 && ((v >> (8 * n - 1)) & 32'd1) != 0) v = v | ~mask;
    return v;
  endfunction

  // One complete MEM-stage access; ack_at is the WAIT cycle carrying bus_ack (beyond TO = none).
  task automatic run_txn(input logic we, input logic [1:0] whb, input logic [31:0] addr,
                         input logic [31:0] wd, input logic uns, input int ack_at,
                         input logic [31:0] rd, input bit drop_req);
    bit timed = 0;
    int k;
    @(negedge clk);
    memreqM = 1'b1; memwriteM = we; aluoutM = addr; writedataM = wd;
    whbM = whb; lunsignedM = uns; bus_ack = 1'b0;
    #1;
    if (is_mis(whb, addr)) begin
      chk("mis_stall", stallM, 1'b0);
      @(negedge clk); memreqM = 1'b0; #1;
      chk("mis_pulse", misalignM, 1'b1);
      chk("mis_noreq", bus_req, 1'b0);
      chk("mis_rdata", readdataM, 32'd0);
      model_rd = 32'd0;
      @(negedge clk); #1;
      chk("mis_pulse_end", misalignM, 1'b0);
      chk("mis_noreq2", bus_req, 1'b0);
      $display("txn mis  we=%0b whb=%b addr=%h", we, whb, addr);
      return;
    end
    chk("stall_c0", stallM, 1'b1);
    chk("req_c0", bus_req, 1'b0);
    for (k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (drop_req) memreqM = 1'b0;
      bus_ack = (k == ack_at);
      bus_rdata = (k == ack_at) ? rd : $urandom;
      #1;
      chk("wait_req", bus_req, 1'b1);
      chk("wait_stall", stallM, 1'b1);
      chk("wait_addr", bus_addr, addr & 32'hFFFF_FFFC);
      chk("wait_be", bus_be, exp_be(whb, addr));
      chk("wait_wdata", bus_wdata, exp_wdata(whb, wd));
      chk("wait_we", bus_we, we);
      if (k == ack_at) break;
      if (k == TO) timed = 1;
    end
    if (timed) model_rd = 32'd0;
    else if (!we) model_rd = exp_load(whb, addr, rd, uns);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("done_stall", stallM, 1'b0);
    chk("done_req", bus_req, 1'b0);
    chk("done_fault", busfault, timed);
    chk("done_rdata", readdataM, model_rd);
    @(negedge clk);
    memreqM = 1'b0;
    bus_ack = 1'($urandom % 2);
    #1;
    chk("idle_stall", stallM, 1'b0);
    chk("idle_fault", busfault, 1'b0);
    chk("idle_req", bus_req, 1'b0);
    $display("txn %s we=%0b whb=%b addr=%h wd=%h uns=%0b ack_at=%0d rd=%h -> rdata=%h fault=%0b",
             timed ? "tmo " : "ok  ", we, whb, addr, wd, uns, ack_at, rd, readdataM, timed);
  endtask

  initial begin
    reset = 1'b0; memreqM = 0; memwriteM = 0; aluoutM = 0; writedataM = 0;
    whbM = 0; lunsignedM = 0; bus_rdata = 0; bus_ack = 0;
    @(negedge clk); #1;
    chk("rst_req", bus_req, 1'b0);
    chk("rst_be", bus_be, 4'b0000);
    chk("rst_rdata", readdataM, 32'd0);
    chk("rst_stall", stallM, 1'b0);
    chk("rst_addr", bus_addr, 32'd0);
    reset = 1'b1;

    // Directed cases
    run_txn(1'b0, 2'b10, 32'h103, 32'h0, 1'b0, 1, 32'h80FF_FF11, 0);
    chk("d_lb_signed", readdataM, 32'hFFFF_FF80);
    run_txn(1'b1, 2'b01, 32'h202, 32'h1234_ABCD, 1'b0, 3, 32'h0, 0);
    chk("d_store_keeps", readdataM, 32'hFFFF_FF80);
    run_txn(1'b0, 2'b00, 32'h105, 32'h0, 1'b0, 1, 32'h0, 0);
    run_txn(1'b0, 2'b00, 32'h40, 32'h0, 1'b0, TO + 2, 32'h0, 0);
    run_txn(1'b0, 2'b00, 32'h44, 32'h0, 1'b0, TO, 32'hCAFE_F00D, 1);
    chk("d_ack_wins", readdataM, 32'hCAFE_F00D);
    run_txn(1'b0, 2'b01, 32'h002, 32'h0, 1'b1, 2, 32'hF00D_0000, 0);
    chk("d_lhu", readdataM, 32'h0000_F00D);
    run_txn(1'b0, 2'b11, 32'h08, 32'h0, 1'b0, 1, 32'h1357_9BDF, 0);

    // Reset in the middle of WAIT
    @(negedge clk);
    memreqM = 1; memwriteM = 0; aluoutM = 32'h300; whbM = 2'b00; lunsignedM = 0; bus_ack = 0;
    @(negedge clk); memreqM = 0; #1;
    chk("mid_req_before", bus_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_req_drop", bus_req, 1'b0);
    chk("mid_be", bus_be, 4'b0000);
    chk("mid_rdata", readdataM, 32'd0);
    chk("mid_stall", stallM, 1'b0);
    chk("mid_addr", bus_addr, 32'd0);
    model_rd = 32'd0;
    @(negedge clk); reset = 1'b1;
    run_txn(1'b0, 2'b00, 32'h304, 32'h0, 1'b0, 2, 32'h0BAD_BEEF, 0);
    chk("post_rst", readdataM, 32'h0BAD_BEEF);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  whb = 2'($urandom);
      logic [31:0] a = $urandom;
      if ($urandom % 4 != 0) a = a & ~(32'(nbytes(whb)) - 32'd1);
      run_txn(1'($urandom), whb, a, $urandom, 1'($urandom), int'($urandom_range(1, TO + 2)),
              $urandom, 1'($urandom % 3 == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
